// File: rtl/period_meter.sv
// Period / high-time meter: counts clk cycles between synchronized rising
// edges of in_sig, with optional back-to-back mode and an edge-wait timeout.
module period_meter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_sig,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [CNT_WIDTH-1:0] timeout_cycles,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 valid,
  output logic                 timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEAS} state_t;

  localparam logic [CNT_WIDTH-1:0] ALL1 = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state, w_next;
  logic                 r_sync1, r_s, r_prev;
  logic [CNT_WIDTH-1:0] r_cnt, r_hcnt, r_tcnt;
  logic [CNT_WIDTH-1:0] r_period, r_high;
  logic                 r_valid, r_timeout;
  logic                 w_e, w_to_hit, w_cap, w_abort, w_restart;

  assign w_e = r_s & ~r_prev;
  // An edge in the expiry cycle takes priority over the timeout.
  assign w_to_hit = (timeout_cycles != '0) && (r_tcnt == timeout_cycles - ONE) && !w_e;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_WAIT;
      S_WAIT: begin
        if (w_e)           w_next = S_MEAS;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_MEAS: begin
        if (w_e)           w_next = continuous ? S_MEAS : S_IDLE;
        else if (w_to_hit) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    w_cap     = (r_state == S_MEAS) && w_e;
    w_abort   = (r_state != S_IDLE) && w_to_hit;
    w_restart = (r_state != S_IDLE) && w_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_s       <= 1'b0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_tcnt    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync1   <= in_sig;
      r_s       <= r_sync1;
      r_prev    <= r_s;
      r_valid   <= w_cap;
      r_timeout <= w_abort;
      if (w_cap) begin
        r_period <= r_cnt;
        r_high   <= r_hcnt;
      end
      if (r_state == S_IDLE) begin
        r_tcnt <= '0;
      end else if (w_restart) begin
        r_cnt  <= ONE;
        r_hcnt <= ONE;
        r_tcnt <= '0;
      end else begin
        if (r_tcnt != ALL1) r_tcnt <= r_tcnt + ONE;
        // Counters only advance while measuring and saturate instead of wrapping.
        if (r_state == S_MEAS) begin
          if (r_cnt != ALL1)         r_cnt  <= r_cnt + ONE;
          if (r_s && r_hcnt != ALL1) r_hcnt <= r_hcnt + ONE;
        end
      end
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign valid      = r_valid;
  assign timeout    = r_timeout;

endmodule
